// File: rtl/prewish_button_poller.sv
// prewish_button_poller
// Periodically strobes an external button responder, waits for its one-cycle
// "data ready" strobe, captures the status byte and reports press/release
// edges. A missing response within the timeout window raises a sticky flag.
module prewish_button_poller #(
    parameter int POLL_PERIOD    = 1200,
    parameter int PERIOD_BITS    = 11,
    parameter int STROBE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    output logic       STB_O,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    input  logic       i_poll_now,
    output logic [7:0] o_buttons,
    output logic [7:0] o_pressed,
    output logic [7:0] o_released,
    output logic       o_valid,
    output logic       o_timeout,
    output logic       o_alive
);

    localparam int STB_BITS = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int RSP_BITS = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PERIOD_BITS-1:0] TIMER_RELOAD = PERIOD_BITS'(POLL_PERIOD - 1);
    localparam logic [STB_BITS-1:0]    STB_LAST     = STB_BITS'(STROBE_CYCLES - 1);
    localparam logic [RSP_BITS-1:0]    RSP_MAX      = RSP_BITS'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT_RSP,
        S_CAPTURE
    } state_t;

    state_t                 r_state;
    logic [PERIOD_BITS-1:0] r_timer;
    logic [STB_BITS-1:0]    r_stb_cnt;
    logic [RSP_BITS-1:0]    r_rsp_cnt;
    logic [7:0]             r_hold;
    logic                   r_stb;
    logic [7:0]             r_buttons;
    logic [7:0]             r_pressed;
    logic [7:0]             r_released;
    logic                   r_valid;
    logic                   r_timeout;
    logic                   r_alive;

    logic [RSP_BITS-1:0]    w_rsp_next;
    logic                   w_rsp_expired;
    logic                   w_poll_start;

    // The response counter saturates at the timeout value; the window expires
    // on the edge where the count would reach TIMEOUT_CYCLES.
    assign w_rsp_next    = (r_rsp_cnt == RSP_MAX) ? r_rsp_cnt : r_rsp_cnt + 1'b1;
    assign w_rsp_expired = (w_rsp_next == RSP_MAX);

    // A timer expiry and a manual request on the same cycle start one poll.
    assign w_poll_start  = (r_timer == '0) || i_poll_now;

    // Poll sequencer: strobe, wait for response or timeout, publish the capture.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state    <= S_IDLE;
            r_timer    <= TIMER_RELOAD;
            r_stb_cnt  <= '0;
            r_rsp_cnt  <= '0;
            r_stb      <= 1'b0;
            r_buttons  <= 8'h00;
            r_pressed  <= 8'h00;
            r_released <= 8'h00;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_alive    <= 1'b1;
        end else begin
            // Edge reports exist only alongside the valid pulse.
            r_valid    <= 1'b0;
            r_pressed  <= 8'h00;
            r_released <= 8'h00;

            case (r_state)
                S_IDLE: begin
                    if (w_poll_start) begin
                        r_timer   <= TIMER_RELOAD;
                        r_stb_cnt <= '0;
                        r_stb     <= 1'b1;
                        r_state   <= S_STROBE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                S_STROBE: begin
                    if (r_stb_cnt == STB_LAST) begin
                        r_stb     <= 1'b0;
                        r_rsp_cnt <= '0;
                        r_state   <= S_WAIT_RSP;
                    end else begin
                        r_stb_cnt <= r_stb_cnt + 1'b1;
                    end
                end

                S_WAIT_RSP: begin
                    // A response on the final window cycle still wins over the timeout.
                    if (STB_I) begin
                        r_state <= S_CAPTURE;
                    end else if (w_rsp_expired) begin
                        r_rsp_cnt <= w_rsp_next;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_rsp_cnt <= w_rsp_next;
                    end
                end

                S_CAPTURE: begin
                    r_buttons  <= r_hold;
                    r_pressed  <= r_hold & ~r_buttons;
                    r_released <= ~r_hold & r_buttons;
                    r_valid    <= 1'b1;
                    r_timeout  <= 1'b0;
                    r_alive    <= ~r_alive;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_stb   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Holding register for the responder byte, loaded only on an accepted response.
    always_ff @(posedge CLK_I) begin
        if (r_state == S_WAIT_RSP && STB_I) begin
            r_hold <= DAT_I;
        end
    end

    assign STB_O      = r_stb;
    assign o_buttons  = r_buttons;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;
    assign o_valid    = r_valid;
    assign o_timeout  = r_timeout;
    assign o_alive    = r_alive;

endmodule

// File: doc/prewish_button_poller.md
PREWISH_BUTTON_POLLER -- requirements
Module: prewish_button_poller

Interface
REQ-001 The block SHALL have parameter POLL_PERIOD, default 1200, meaning clocks between poll starts (10 kHz at 12 MHz).
REQ-002 The block SHALL have parameter PERIOD_BITS, default 11, meaning poll timer width, which must hold POLL_PERIOD-1.
REQ-003 The block SHALL have parameter STROBE_CYCLES, default 2, meaning STB_O high time per poll, with a minimum of 1.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 15, meaning clocks allowed for the response after STB_O falls.
REQ-005 The block SHALL have port CLK_I, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port RST_I, input, 1 bit, reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port STB_O, output, 1 bit, the poll request strobe driven to the responder.
REQ-008 The block SHALL have port STB_I, input, 1 bit, the responder's one-cycle "data ready" strobe.
REQ-009 The block SHALL have port DAT_I, input, 8 bits, the responder's button status byte, active-high.
REQ-010 The block SHALL have port i_poll_now, input, 1 bit, a request for an immediate poll when idle.
REQ-011 The block SHALL have port o_buttons, output, 8 bits, the last successfully captured status byte.
REQ-012 The block SHALL have port o_pressed, output, 8 bits, the bits that went 0->1 at the last capture.
REQ-013 The block SHALL have port o_released, output, 8 bits, the bits that went 1->0 at the last capture.
REQ-014 The block SHALL have port o_valid, output, 1 bit, a one-cycle pulse on each o_buttons update.
REQ-015 The block SHALL have port o_timeout, output, 1 bit, a sticky flag meaning the last poll got no response.
REQ-016 The block SHALL have port o_alive, output, 1 bit, which toggles on each successful poll (debug LED).

Function
REQ-017 The FSM SHALL have states IDLE, STROBE, WAIT_RSP and CAPTURE, and all outputs SHALL be registered.
REQ-018 In IDLE, the timer SHALL count down; timer==0 or i_poll_now=1 SHALL cause the transition to STROBE, and the timer SHALL reload to POLL_PERIOD-1 on that transition.
REQ-019 In STROBE, STB_O SHALL be 1 for exactly STROBE_CYCLES cycles and STB_I SHALL be ignored; the block SHALL then drop STB_O and enter WAIT_RSP with the response counter cleared.
REQ-020 In WAIT_RSP, STB_O SHALL be 0; STB_I=1 SHALL register DAT_I on that edge into a holding register and cause the transition to CAPTURE.
REQ-021 In WAIT_RSP, if the response counter reaches TIMEOUT_CYCLES without STB_I, the block SHALL set o_timeout=1, leave o_buttons unchanged, and return to IDLE.
REQ-022 In CAPTURE, a single cycle, the block SHALL update o_buttons to the held byte, set o_pressed = held & ~old o_buttons and o_released = ~held & old o_buttons, pulse o_valid=1, clear o_timeout, toggle o_alive, and return to IDLE.
REQ-023 o_pressed and o_released SHALL be 0 in every cycle where o_valid=0.
REQ-024 Latency from the STB_I=1 cycle to o_valid=1 SHALL be exactly 2 clocks.
REQ-025 STB_I pulses arriving in IDLE or STROBE SHALL be ignored, with no capture and no state change.
REQ-026 i_poll_now SHALL be ignored outside IDLE and SHALL NOT be queued.
REQ-027 i_poll_now asserted in the same cycle that the timer reaches 0 SHALL start exactly one poll.
REQ-028 A STB_I pulse on the same cycle the response counter reaches TIMEOUT_CYCLES SHALL take precedence as a valid response, with no timeout.
REQ-029 The poll timer SHALL wrap only by reload and SHALL never underflow.
REQ-030 The response counter SHALL saturate and SHALL NOT wrap.

Reset
REQ-031 RST_I=0 SHALL immediately force state IDLE, STB_O=0, o_buttons=0, o_pressed=0, o_released=0, o_valid=0, o_timeout=0, o_alive=1, timer=POLL_PERIOD-1, and response counter=0.
REQ-032 Reset asserted mid-poll SHALL abort the poll, and the block SHALL produce no o_valid afterwards.
REQ-033 The first poll after reset release SHALL start POLL_PERIOD clocks later, or earlier via i_poll_now.

Verification
REQ-034 The bench SHALL run a normal poll with POLL_PERIOD=8: responder answers STB_I one cycle after STB_O falls with DAT_I=0x05 -> o_buttons=0x05, o_pressed=0x05, o_released=0x00, o_valid for one cycle 2 clocks after STB_I, o_alive=0.
REQ-035 The bench SHALL run a second poll with DAT_I=0x06 -> o_buttons=0x06, o_pressed=0x02, o_released=0x01, o_alive=1.
REQ-036 The bench SHALL run a timeout case with no STB_I after STB_O falls -> o_timeout=1 after 15 clocks, o_buttons held at 0x06, no o_valid; a subsequent good poll clears o_timeout.
REQ-037 The bench SHALL pulse i_poll_now in IDLE -> STB_O high on the next cycle for STROBE_CYCLES=2 cycles; i_poll_now during WAIT_RSP -> no extra poll.
REQ-038 The bench SHALL drive a stray STB_I in IDLE with DAT_I=0xFF -> o_buttons unchanged, no o_valid.
REQ-039 The bench SHALL assert RST_I=0 between an STB_I pulse and CAPTURE -> all outputs at reset values asynchronously, no o_valid, and the next poll occurs POLL_PERIOD clocks after release.
